// File: rtl/fault_test_sequencer.sv
// Fault test sequencer: issues one test vector to the golden and fault-injected
// CUT copies, waits for both ready flags (with timeout), and returns a diff record.
module fault_test_sequencer #(
    parameter int TV_W     = 70,
    parameter int RV_W     = 41,
    parameter int RDY_BIT  = 32,
    parameter int MIN_WAIT = 2,
    parameter int TIMEOUT  = 64,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [TV_W-2:0]  cmd_vector,
    output logic [TV_W-1:0]  cut_test_vector,
    input  logic [RV_W-1:0]  gold_result,
    input  logic [RV_W-1:0]  fault_result,
    output logic             inj_enable,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [RV_W-1:0]  rsp_result,
    output logic [RV_W-1:0]  rsp_diff,
    output logic             rsp_timeout,
    input  logic             clear_counts,
    output logic [CNT_W-1:0] test_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int WC_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [TV_W-2:0]   vec_q, vec_d;
    logic              start_q, start_d;
    logic              inj_q, inj_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              gold_done_q, gold_done_d;
    logic              fault_done_q, fault_done_d;
    logic [RV_W-1:0]   result_q, result_d;
    logic [RV_W-1:0]   diff_q, diff_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  test_count_q, test_count_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;

    logic gold_rdy, fault_rdy, handshake;

    assign gold_rdy        = gold_result[RDY_BIT];
    assign fault_rdy       = fault_result[RDY_BIT];
    assign handshake       = (state_q == S_RESP) && rsp_ready;
    assign cmd_ready       = (state_q == S_IDLE);
    assign rsp_valid       = (state_q == S_RESP);
    assign cut_test_vector = {start_q, vec_q};
    assign inj_enable      = inj_q;
    assign rsp_result      = result_q;
    assign rsp_diff        = diff_q;
    assign rsp_timeout     = timeout_q;
    assign test_count      = test_count_q;
    assign err_count       = err_count_q;

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        start_d      = start_q;
        inj_d        = inj_q;
        wait_cnt_d   = wait_cnt_q;
        gold_done_d  = gold_done_q;
        fault_done_d = fault_done_q;
        result_d     = result_q;
        diff_d       = diff_q;
        timeout_d    = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    vec_d        = cmd_vector;
                    start_d      = 1'b1;
                    inj_d        = 1'b1;
                    wait_cnt_d   = '0;
                    gold_done_d  = 1'b0;
                    fault_done_d = 1'b0;
                    state_d      = S_START;
                end
            end
            S_START: begin
                start_d = 1'b0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                // Early ready flags may be left over from the previous operation.
                if (wait_cnt_q >= WC_W'(MIN_WAIT)) begin
                    if (gold_rdy) gold_done_d = 1'b1;
                    if (fault_rdy && !fault_done_q) begin
                        fault_done_d = 1'b1;
                        result_d     = fault_result;
                        diff_d       = gold_result ^ fault_result;
                    end else if (gold_rdy && !gold_done_q && fault_done_q) begin
                        diff_d = result_q ^ gold_result;
                    end
                end
                if (gold_done_d && fault_done_d) begin
                    timeout_d = 1'b0;
                    inj_d     = 1'b0;
                    state_d   = S_RESP;
                end else if (wait_cnt_q == WC_W'(TIMEOUT - 1)) begin
                    result_d  = fault_result;
                    diff_d    = gold_result ^ fault_result;
                    timeout_d = 1'b1;
                    inj_d     = 1'b0;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Saturating statistics; a clear wins over a same-cycle increment.
    always_comb begin
        test_count_d = test_count_q;
        err_count_d  = err_count_q;
        if (clear_counts) begin
            test_count_d = '0;
            err_count_d  = '0;
        end else if (handshake) begin
            if (test_count_q != '1) test_count_d = test_count_q + 1'b1;
            if ((timeout_q || (|diff_q)) && (err_count_q != '1))
                err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            vec_q        <= '0;
            start_q      <= 1'b0;
            inj_q        <= 1'b0;
            wait_cnt_q   <= '0;
            gold_done_q  <= 1'b0;
            fault_done_q <= 1'b0;
            result_q     <= '0;
            diff_q       <= '0;
            timeout_q    <= 1'b0;
            test_count_q <= '0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            start_q      <= start_d;
            inj_q        <= inj_d;
            wait_cnt_q   <= wait_cnt_d;
            gold_done_q  <= gold_done_d;
            fault_done_q <= fault_done_d;
            result_q     <= result_d;
            diff_q       <= diff_d;
            timeout_q    <= timeout_d;
            test_count_q <= test_count_d;
            err_count_q  <= err_count_d;
        end
    end

endmodule

// File: tb/tb_fault_test_sequencer.sv
// Directed bench for fault_test_sequencer: a CUT-pair driver plus a response
// scoreboard filled at command time and drained when rsp_valid appears.
module tb_fault_test_sequencer;

    localparam int TV_W     = 70;
    localparam int RV_W     = 41;
    localparam int MIN_WAIT = 2;
    localparam int TIMEOUT  = 64;
    localparam int CNT_W    = 32;

    localparam logic [RV_W-1:0] RDY_MASK = 41'h1_0000_0000;
    localparam logic [RV_W-1:0] STALE    = 41'h1_DEAD_0000;
    localparam logic [RV_W-1:0] JUNK_G   = 41'h0_1234_ABCD;
    localparam logic [RV_W-1:0] JUNK_F   = 41'h0_0F0F_0F0F;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [TV_W-2:0]   cmd_vector;
    logic [TV_W-1:0]   cut_test_vector;
    logic [RV_W-1:0]   gold_result;
    logic [RV_W-1:0]   fault_result;
    logic              inj_enable;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [RV_W-1:0]   rsp_result;
    logic [RV_W-1:0]   rsp_diff;
    logic              rsp_timeout;
    logic              clear_counts;
    logic [CNT_W-1:0]  test_count;
    logic [CNT_W-1:0]  err_count;

    typedef struct {
        logic [RV_W-1:0] result;
        logic [RV_W-1:0] diff;
        logic            timeout;
        int              latency;
    } exp_t;

    exp_t            sb[$];
    int              n_checks = 0;
    int              n_fails  = 0;
    int              last_latency;
    logic [CNT_W-1:0] exp_tests = '0;
    logic [CNT_W-1:0] exp_errs  = '0;

    fault_test_sequencer #(
        .TV_W(TV_W), .RV_W(RV_W), .RDY_BIT(32), .MIN_WAIT(MIN_WAIT),
        .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_vector(cmd_vector),
        .cut_test_vector(cut_test_vector),
        .gold_result(gold_result), .fault_result(fault_result),
        .inj_enable(inj_enable),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_diff(rsp_diff), .rsp_timeout(rsp_timeout),
        .clear_counts(clear_counts), .test_count(test_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one command and play both CUT copies until a response shows up.
    task automatic applyStimulus(input logic [TV_W-2:0] vec, input logic [RV_W-1:0] gdata,
                                 input logic [RV_W-1:0] fdata, input int gcyc, input int fcyc,
                                 input bit stale);
        exp_t            e;
        logic [RV_W-1:0] gval, fval, g_last, f_last;
        int              g_eff, f_eff, done, k;
        bit              inj_ok;
        logic [TV_W-1:0] ctv;
        gval  = gdata | RDY_MASK;
        fval  = fdata | RDY_MASK;
        g_eff = (gcyc < 0) ? -1 : ((gcyc < MIN_WAIT) ? MIN_WAIT : gcyc);
        f_eff = (fcyc < 0) ? -1 : ((fcyc < MIN_WAIT) ? MIN_WAIT : fcyc);
        done  = (g_eff > f_eff) ? g_eff : f_eff;
        if (g_eff >= 0 && f_eff >= 0 && done <= TIMEOUT - 1) begin
            e.result  = fval;
            e.diff    = gval ^ fval;
            e.timeout = 1'b0;
            e.latency = done + 1;
        end else begin
            g_last    = (gcyc >= 0 && TIMEOUT - 1 >= gcyc) ? gval : JUNK_G;
            f_last    = (fcyc >= 0 && TIMEOUT - 1 >= fcyc) ? fval : JUNK_F;
            e.result  = f_last;
            e.diff    = g_last ^ f_last;
            e.timeout = 1'b1;
            e.latency = TIMEOUT;
        end
        sb.push_back(e);

        checkOutput("cmd_ready_idle", 70'(cmd_ready), 70'(1));
        cmd_valid  = 1'b1;
        cmd_vector = vec;
        @(negedge clk);
        checkOutput("start_cmd_ready", 70'(cmd_ready), 70'(0));
        checkOutput("start_inj", 70'(inj_enable), 70'(1));
        checkOutput("start_vector", 70'(cut_test_vector), {1'b1, vec});
        cmd_valid    = 1'b0;
        gold_result  = stale ? STALE : JUNK_G;
        fault_result = stale ? STALE : JUNK_F;
        @(negedge clk);
        ctv = cut_test_vector;
        checkOutput("start_pulse_end", 70'(ctv[TV_W-1]), 70'(0));
        checkOutput("operands_held", 70'(ctv[TV_W-2:0]), 70'(vec));
        k      = 0;
        inj_ok = 1'b1;
        while (rsp_valid !== 1'b1 && k <= TIMEOUT + 4) begin
            if (inj_enable !== 1'b1) inj_ok = 1'b0;
            gold_result  = (stale && k == 0) ? STALE : ((gcyc >= 0 && k >= gcyc) ? gval : JUNK_G);
            fault_result = (stale && k == 0) ? STALE : ((fcyc >= 0 && k >= fcyc) ? fval : JUNK_F);
            @(negedge clk);
            k++;
        end
        last_latency = k;
        checkOutput("inj_during_wait", 70'(inj_ok), 70'(1));
    endtask

    // Pop the expected record, optionally stall, then complete the handshake.
    task automatic receiveResponse(input int stall, input bit clr);
        exp_t e;
        bit   err;
        if (sb.size() == 0) begin
            n_checks++;
            n_fails++;
            $error("[TB] FAIL scoreboard_empty: observed empty queue, expected a record");
            return;
        end
        e = sb.pop_front();
        checkOutput("latency", 70'(last_latency), 70'(e.latency));
        checkOutput("rsp_valid", 70'(rsp_valid), 70'(1));
        checkOutput("rsp_result", 70'(rsp_result), 70'(e.result));
        checkOutput("rsp_diff", 70'(rsp_diff), 70'(e.diff));
        checkOutput("rsp_timeout", 70'(rsp_timeout), 70'(e.timeout));
        checkOutput("resp_inj_off", 70'(inj_enable), 70'(0));
        checkOutput("resp_cmd_ready", 70'(cmd_ready), 70'(0));
        for (int i = 0; i < stall; i++) begin
            rsp_ready  = 1'b0;
            cmd_valid  = 1'b1;
            cmd_vector = 69'h0_5555_AAAA;
            @(negedge clk);
            checkOutput("stall_valid", 70'(rsp_valid), 70'(1));
            checkOutput("stall_cmd_ready", 70'(cmd_ready), 70'(0));
            checkOutput("stall_result", 70'(rsp_result), 70'(e.result));
            checkOutput("stall_diff", 70'(rsp_diff), 70'(e.diff));
        end
        cmd_valid    = 1'b0;
        rsp_ready    = 1'b1;
        clear_counts = clr;
        @(negedge clk);
        rsp_ready    = 1'b0;
        clear_counts = 1'b0;
        err = e.timeout || (|e.diff);
        if (clr) begin
            exp_tests = '0;
            exp_errs  = '0;
        end else begin
            if (exp_tests != '1) exp_tests = exp_tests + 1'b1;
            if (err && exp_errs != '1) exp_errs = exp_errs + 1'b1;
        end
        checkOutput("post_rsp_valid", 70'(rsp_valid), 70'(0));
        checkOutput("post_cmd_ready", 70'(cmd_ready), 70'(1));
        checkOutput("test_count", 70'(test_count), 70'(exp_tests));
        checkOutput("err_count", 70'(err_count), 70'(exp_errs));
    endtask

    initial begin
        bit quiet;
        rst          = 1'b0;
        cmd_valid    = 1'b0;
        cmd_vector   = '0;
        gold_result  = '0;
        fault_result = '0;
        rsp_ready    = 1'b0;
        clear_counts = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_ctv", 70'(cut_test_vector), 70'(0));
        checkOutput("reset_inj", 70'(inj_enable), 70'(0));
        checkOutput("reset_rsp_valid", 70'(rsp_valid), 70'(0));
        checkOutput("reset_rsp_result", 70'(rsp_result), 70'(0));
        checkOutput("reset_rsp_diff", 70'(rsp_diff), 70'(0));
        checkOutput("reset_rsp_timeout", 70'(rsp_timeout), 70'(0));
        checkOutput("reset_counts", {6'd0, test_count, err_count}, 70'(0));
        checkOutput("reset_cmd_ready", 70'(cmd_ready), 70'(1));
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] matching results, no fault");
        applyStimulus(69'h0_3F80_0000_4000_0000, 41'h0_3F00_0000, 41'h0_3F00_0000, 5, 5, 1'b0);
        receiveResponse(0, 1'b0);

        $display("[TB] single-bit fault, fault copy ready first");
        applyStimulus(69'h1_4040_0000_3F80_0000, 41'h0_3F00_0000, 41'h0_3F00_0008, 5, 3, 1'b0);
        receiveResponse(0, 1'b0);

        $display("[TB] stale ready filter");
        applyStimulus(69'h0_4100_0000_4000_0000, 41'h0_4080_0000, 41'h0_4080_0000, 6, 6, 1'b1);
        receiveResponse(0, 1'b0);

        $display("[TB] gold ready at MIN_WAIT, fault differs in bit 40");
        applyStimulus(69'h0_0000_0001_0000_0003, 41'h0_0000_0003, 41'h100_0000_0003, MIN_WAIT, 4, 1'b0);
        receiveResponse(0, 1'b0);

        $display("[TB] timeout, fault copy never ready");
        applyStimulus(69'h0_C000_0000_4000_0000, 41'h0_C000_0000, 41'h0_0000_0000, 1, -1, 1'b0);
        receiveResponse(0, 1'b0);

        $display("[TB] backpressure plus clear");
        applyStimulus(69'h0_3F80_0000_3F80_0000, 41'h0_3F80_0000, 41'h0_3F80_0001, 3, 3, 1'b0);
        receiveResponse(10, 1'b1);

        applyStimulus(69'h0_4000_0000_4000_0000, 41'h0_3F80_0000, 41'h0_3F80_0010, 2, 7, 1'b0);
        receiveResponse(0, 1'b0);

        $display("[TB] async reset mid-WAIT");
        cmd_valid  = 1'b1;
        cmd_vector = 69'h0_1111_2222_3333_4444;
        @(negedge clk);
        cmd_valid    = 1'b0;
        gold_result  = JUNK_G;
        fault_result = JUNK_F;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("midrst_ctv", 70'(cut_test_vector), 70'(0));
        checkOutput("midrst_inj", 70'(inj_enable), 70'(0));
        checkOutput("midrst_rsp", {rsp_valid, rsp_timeout, rsp_result, rsp_diff}, 70'(0));
        checkOutput("midrst_counts", {6'd0, test_count, err_count}, 70'(0));
        #1 rst = 1'b1;
        exp_tests = '0;
        exp_errs  = '0;
        @(negedge clk);
        checkOutput("midrst_cmd_ready", 70'(cmd_ready), 70'(1));
        gold_result  = 41'h1_3F00_0000;
        fault_result = 41'h1_3F00_0000;
        quiet = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) quiet = 1'b0;
        end
        checkOutput("midrst_no_response", 70'(quiet), 70'(1));

        $display("[TB] normal test after reset");
        applyStimulus(69'h0_4040_0000_4000_0000, 41'h0_3FC0_0000, 41'h0_3FC0_0000, 4, 2, 1'b0);
        receiveResponse(0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/fault_test_sequencer.md
Name: fault_test_sequencer

Overview:
- Sequences one divider test vector at a time into a golden and a fault-injected copy of the circuit under test.
- Pulses the start bit, then waits for both ready flags, with a timeout.
- Captures and compares the two 41-bit result vectors and returns a per-test response record.
- Sits between the AXI-side test-vector FIFO and the circuit_under_test pair. It also gates the injection vector so faults are active only while a test is in flight.

Parameters:
- TV_W, 70, test vector width; bit TV_W-1 is the start bit.
- RV_W, 41, result vector width.
- RDY_BIT, 32, index of the ready flag inside the result vector.
- MIN_WAIT, 2, cycles after start during which ready is ignored (stale ready from the previous operation).
- TIMEOUT, 64, maximum WAIT-state cycles before abort; must exceed MIN_WAIT.
- CNT_W, 32, statistics counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  a test vector is offered.
- cmd_ready  out  1  sequencer accepts a test vector.
- cmd_vector  in  TV_W-1  operands, operation and rounding mode; the start bit is excluded.
- cut_test_vector  out  TV_W  driven to both copies; bits TV_W-2:0 hold the operands, bit TV_W-1 is start.
- gold_result  in  RV_W  result vector of the fault-free copy.
- fault_result  in  RV_W  result vector of the injected copy.
- inj_enable  out  1  high while a test is in flight; ANDed with the injection vector outside this block.
- rsp_valid  out  1  response record available.
- rsp_ready  in  1  response consumer ready.
- rsp_result  out  RV_W  captured fault_result.
- rsp_diff  out  RV_W  gold_result XOR fault_result at capture.
- rsp_timeout  out  1  test aborted by timeout.
- clear_counts  in  1  synchronous clear of statistics.
- test_count  out  CNT_W  completed tests (including timeouts).
- err_count  out  CNT_W  tests with a nonzero rsp_diff or a timeout.

Behaviour:
- Reset (rst=0, async):
  - State is IDLE.
  - cut_test_vector, inj_enable, rsp_valid, rsp_result, rsp_diff, rsp_timeout, test_count and err_count are all 0.
  - cmd_ready is 1 (combinational from IDLE).
  - The wait counter and the gold_done/fault_done flags are 0.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready:
  - latch cmd_vector into cut_test_vector[TV_W-2:0];
  - set the start bit and inj_enable;
  - clear the wait counter and both done flags;
  - go to START.
- START (exactly 1 cycle): cmd_ready=0. The start bit is cleared at the end of the cycle, giving a one-cycle start pulse. Go to WAIT.
- WAIT:
  - The wait counter increments every cycle.
  - While counter < MIN_WAIT, ready bits are ignored.
  - Otherwise:
    - gold_result[RDY_BIT]=1 sets gold_done and captures nothing.
    - fault_result[RDY_BIT]=1 sets fault_done and captures fault_result plus the XOR of the current gold_result and fault_result.
    - If gold_done is already set, or both ready bits are high in the same cycle, capture uses the current values.
  - When both done flags are set (including flags set this cycle): rsp_timeout=0, clear inj_enable, go to RESP.
  - If gold is done last, the XOR is recomputed using the held fault capture and the current gold_result.
  - If counter reaches TIMEOUT-1 without both done: capture the current fault_result and XOR anyway, rsp_timeout=1, clear inj_enable, go to RESP.
- RESP:
  - rsp_valid=1; the response fields are held stable until rsp_valid&rsp_ready.
  - On handshake: rsp_valid drops next cycle and state returns to IDLE. The next cmd can be accepted one cycle after the handshake; there is no same-cycle bypass.
- Counters:
  - Updated in the cycle of the RESP handshake: test_count+1, and err_count+1 if rsp_timeout or |rsp_diff.
  - Both counters saturate at all-ones.
  - clear_counts zeroes both and takes priority over a simultaneous increment.
- cut_test_vector[TV_W-2:0] holds its value after the test until the next accept.
- A reset mid-test returns to IDLE immediately. A pending response is discarded and the counters clear.
- rsp_ready held low stalls the sequencer indefinitely in RESP. No command is accepted while stalled.

Test Plan:
- Matching results, no fault: cmd 0x3F800000/0x40000000; both copies report ready at cycle 5 after start with identical results.
  - Expect rsp_diff=0, rsp_timeout=0, test_count=1, err_count=0.
  - inj_enable is high from START through the last WAIT cycle.
- Single-bit fault: fault_result differs from gold in bit 3.
  - Expect rsp_diff=0x00000000008, err_count=1, and rsp_result equal to the fault_result value.
- Stale-ready filter: both copies hold ready=1 through START and WAIT cycle 0, drop it, then reassert it at cycle 6.
  - The capture must occur at cycle 6, not earlier.
- Timeout: the fault copy never asserts ready.
  - rsp_valid rises after TIMEOUT WAIT cycles with rsp_timeout=1; err_count increments.
- Backpressure plus clear: rsp_ready is held low for 10 cycles, then pulsed while clear_counts=1.
  - Fields are held stable and cmd_ready stays 0 throughout; both counters read 0 after the handshake.
- Async reset mid-WAIT: drop rst for a partial cycle.
  - All outputs are 0 immediately, cmd_ready=1 after release, and no response is emitted.
